// File: rtl/axis_host_tx.sv
// axis_host_tx: packetizes a raw word stream into TDEST-tagged AXIS packets.
// Define AXIS_HOST_TX_STATS_EN to build the PKT_CNT/WORD_CNT counters.
module axis_host_tx #(
    parameter int DATAW = 32,
    parameter int IDW   = 32,
    parameter int USERW = 32,
    parameter int DESTW = 6,
    parameter int LENW  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [DESTW-1:0] CMD_DEST,
    input  logic [USERW-1:0] CMD_USER,
    input  logic [IDW-1:0]   CMD_ID,
    input  logic [LENW-1:0]  CMD_LEN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic [DATAW-1:0] DIN_DATA,
    output logic             AXIS_M_TVALID,
    input  logic             AXIS_M_TREADY,
    output logic [DATAW-1:0] AXIS_M_TDATA,
    output logic             AXIS_M_TLAST,
    output logic [IDW-1:0]   AXIS_M_TID,
    output logic [USERW-1:0] AXIS_M_TUSER,
    output logic [DESTW-1:0] AXIS_M_TDEST,
    output logic             BUSY,
    output logic [15:0]      PKT_CNT,
    output logic [31:0]      WORD_CNT
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic             cmd_ready_q;
    logic [LENW-1:0]  remaining;
    logic [DESTW-1:0] hdr_dest;
    logic [USERW-1:0] hdr_user;
    logic [IDW-1:0]   hdr_id;

    logic             out_valid;
    logic [DATAW-1:0] out_data;
    logic             out_last;
    logic [IDW-1:0]   out_id;
    logic [USERW-1:0] out_user;
    logic [DESTW-1:0] out_dest;

    logic cmd_fire;
    logic din_fire;
    logic out_fire;
    logic last_word;

    assign cmd_fire  = CMD_VALID && cmd_ready_q;
    assign DIN_READY = (state == SEND) && (!out_valid || AXIS_M_TREADY);
    assign din_fire  = DIN_VALID && DIN_READY;
    assign out_fire  = out_valid && AXIS_M_TREADY;
    assign last_word = (remaining == '0);

    assign CMD_READY     = cmd_ready_q;
    assign AXIS_M_TVALID = out_valid;
    assign AXIS_M_TDATA  = out_data;
    assign AXIS_M_TLAST  = out_last;
    assign AXIS_M_TID    = out_id;
    assign AXIS_M_TUSER  = out_user;
    assign AXIS_M_TDEST  = out_dest;
    assign BUSY          = (state == SEND) || out_valid;

    // CMD_READY is registered so it stays low for one clock after reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            remaining   <= '0;
            hdr_dest    <= '0;
            hdr_user    <= '0;
            hdr_id      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        hdr_dest    <= CMD_DEST;
                        hdr_user    <= CMD_USER;
                        hdr_id      <= CMD_ID;
                        remaining   <= CMD_LEN;
                        state       <= SEND;
                        cmd_ready_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (din_fire) begin
                        if (last_word) begin
                            state       <= IDLE;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // headers are copied per beat so a new command cannot disturb a stalled beat
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
            out_user  <= '0;
            out_dest  <= '0;
        end else if (din_fire) begin
            out_valid <= 1'b1;
            out_data  <= DIN_DATA;
            out_last  <= last_word;
            out_id    <= hdr_id;
            out_user  <= hdr_user;
            out_dest  <= hdr_dest;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AXIS_HOST_TX_STATS_EN
    logic [15:0] pkt_cnt;
    logic [31:0] word_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pkt_cnt  <= '0;
            word_cnt <= '0;
        end else if (out_fire) begin
            word_cnt <= word_cnt + 32'd1;
            if (out_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    assign PKT_CNT  = pkt_cnt;
    assign WORD_CNT = word_cnt;
`else
    assign PKT_CNT  = '0;
    assign WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_axis_host_tx.sv
// tb_axis_host_tx: directed bench for axis_host_tx with a beat monitor.
// Counter expectations follow AXIS_HOST_TX_STATS_EN.
module tb_axis_host_tx;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [5:0]  CMD_DEST;
    logic [31:0] CMD_USER;
    logic [31:0] CMD_ID;
    logic [7:0]  CMD_LEN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [31:0] DIN_DATA;
    logic        AXIS_M_TVALID;
    logic        AXIS_M_TREADY;
    logic [31:0] AXIS_M_TDATA;
    logic        AXIS_M_TLAST;
    logic [31:0] AXIS_M_TID;
    logic [31:0] AXIS_M_TUSER;
    logic [5:0]  AXIS_M_TDEST;
    logic        BUSY;
    logic [15:0] PKT_CNT;
    logic [31:0] WORD_CNT;

    axis_host_tx dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD_DEST     (CMD_DEST),
        .CMD_USER     (CMD_USER),
        .CMD_ID       (CMD_ID),
        .CMD_LEN      (CMD_LEN),
        .DIN_VALID    (DIN_VALID),
        .DIN_READY    (DIN_READY),
        .DIN_DATA     (DIN_DATA),
        .AXIS_M_TVALID(AXIS_M_TVALID),
        .AXIS_M_TREADY(AXIS_M_TREADY),
        .AXIS_M_TDATA (AXIS_M_TDATA),
        .AXIS_M_TLAST (AXIS_M_TLAST),
        .AXIS_M_TID   (AXIS_M_TID),
        .AXIS_M_TUSER (AXIS_M_TUSER),
        .AXIS_M_TDEST (AXIS_M_TDEST),
        .BUSY         (BUSY),
        .PKT_CNT      (PKT_CNT),
        .WORD_CNT     (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0]  dest;
        logic [31:0] user;
        logic [31:0] id;
        logic [7:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [5:0]  dest;
        logic [31:0] id;
        logic [31:0] user;
    } beat_t;

    cmd_t        cmd_q[$];
    logic [31:0] din_q[$];
    beat_t       beats[$];
    int          beat_cyc[$];

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    logic  cmd_fire = 1'b0;
    logic  din_fire = 1'b0;
    logic  toggle = 1'b0;
    logic  stalled = 1'b0;
    beat_t held;

    task automatic chk(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.data = AXIS_M_TDATA;
        b.last = AXIS_M_TLAST;
        b.dest = AXIS_M_TDEST;
        b.id   = AXIS_M_TID;
        b.user = AXIS_M_TUSER;
        return b;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // handshakes and AXIS hold rules observed mid-cycle
    always @(negedge CLK) begin
        cmd_fire = CMD_VALID && CMD_READY;
        din_fire = DIN_VALID && DIN_READY;
        if (!RST_N) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 128'(AXIS_M_TVALID), 128'd1);
                chk("hold_beat", 128'(cur_beat()), 128'(held));
            end
            if (AXIS_M_TVALID && AXIS_M_TREADY) begin
                beats.push_back(cur_beat());
                beat_cyc.push_back(cyc);
            end
            stalled = AXIS_M_TVALID && !AXIS_M_TREADY;
            held    = cur_beat();
        end
    end

    task automatic step();
        cmd_t        c;
        logic [31:0] d;
        @(posedge CLK);
        #1;
        if (cmd_fire && cmd_q.size() > 0) c = cmd_q.pop_front();
        if (din_fire && din_q.size() > 0) d = din_q.pop_front();
        cmd_fire  = 1'b0;
        din_fire  = 1'b0;
        CMD_VALID = cmd_q.size() > 0;
        if (CMD_VALID) begin
            CMD_DEST = cmd_q[0].dest;
            CMD_USER = cmd_q[0].user;
            CMD_ID   = cmd_q[0].id;
            CMD_LEN  = cmd_q[0].len;
        end
        DIN_VALID = din_q.size() > 0;
        if (DIN_VALID) DIN_DATA = din_q[0];
        AXIS_M_TREADY = toggle ? ~AXIS_M_TREADY : 1'b1;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k = 0;
        while (beats.size() < n && k < 200) begin
            step();
            k++;
        end
        chk(tag, 128'(beats.size()), 128'(n));
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        cmd_q     = {};
        din_q     = {};
        CMD_VALID = 1'b0;
        DIN_VALID = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        step();
        beats    = {};
        beat_cyc = {};
    endtask

    function automatic cmd_t mk(input logic [5:0] dest, input logic [31:0] user,
                                input logic [31:0] id, input logic [7:0] len);
        cmd_t c;
        c.dest = dest;
        c.user = user;
        c.id   = id;
        c.len  = len;
        return c;
    endfunction

    initial begin
        RST_N         = 1'b0;
        CMD_VALID     = 1'b0;
        CMD_DEST      = '0;
        CMD_USER      = '0;
        CMD_ID        = '0;
        CMD_LEN       = '0;
        DIN_VALID     = 1'b0;
        DIN_DATA      = '0;
        AXIS_M_TREADY = 1'b1;

        // reset state
        repeat (3) step();
        chk("rst_cmd_ready", 128'(CMD_READY), 128'd0);
        chk("rst_din_ready", 128'(DIN_READY), 128'd0);
        chk("rst_tvalid", 128'(AXIS_M_TVALID), 128'd0);
        chk("rst_beat", 128'(cur_beat()), 128'd0);
        chk("rst_busy", 128'(BUSY), 128'd0);
        chk("rst_cnts", {PKT_CNT, WORD_CNT}, 128'd0);
        RST_N = 1'b1;
        step();
        chk("rel_cmd_ready", 128'(CMD_READY), 128'd1);
        chk("rel_busy", 128'(BUSY), 128'd0);

        // single beat
        cmd_q.push_back(mk(6'h05, 32'h1, 32'h7, 8'd0));
        din_q.push_back(32'hA5A5A5A5);
        wait_beats("single_cnt", 1);
        repeat (3) step();
        chk("single_beat", 128'(beats[0]),
            128'({32'hA5A5A5A5, 1'b1, 6'h05, 32'h7, 32'h1}));
        chk("single_no_dup", 128'(beats.size()), 128'd1);
        chk("single_busy", 128'(BUSY), 128'd0);
        chk("single_cmd_ready", 128'(CMD_READY), 128'd1);

        // backpressure with TREADY toggling
        beats    = {};
        beat_cyc = {};
        toggle   = 1'b1;
        cmd_q.push_back(mk(6'h03, 32'hCAFE, 32'h2, 8'd3));
        for (int i = 1; i <= 4; i++) din_q.push_back(32'(i));
        wait_beats("bp_cnt", 4);
        toggle = 1'b0;
        repeat (4) step();
        chk("bp_no_dup", 128'(beats.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_beat", 128'(beats[i]),
                128'({32'(i + 1), i == 3, 6'h03, 32'h2, 32'hCAFE}));
        end

        // back-to-back packets
        beats    = {};
        beat_cyc = {};
        cmd_q.push_back(mk(6'h01, 32'h11, 32'hA, 8'd1));
        cmd_q.push_back(mk(6'h02, 32'h22, 32'hB, 8'd1));
        din_q.push_back(32'd10);
        din_q.push_back(32'd11);
        din_q.push_back(32'd20);
        din_q.push_back(32'd21);
        wait_beats("b2b_cnt", 4);
        chk("b2b_0", 128'(beats[0]), 128'({32'd10, 1'b0, 6'h01, 32'hA, 32'h11}));
        chk("b2b_1", 128'(beats[1]), 128'({32'd11, 1'b1, 6'h01, 32'hA, 32'h11}));
        chk("b2b_2", 128'(beats[2]), 128'({32'd20, 1'b0, 6'h02, 32'hB, 32'h22}));
        chk("b2b_3", 128'(beats[3]), 128'({32'd21, 1'b1, 6'h02, 32'hB, 32'h22}));
        chk("b2b_rate", 128'(beat_cyc[1] - beat_cyc[0]), 128'd1);
        chk("b2b_gap", 128'(beat_cyc[2] - beat_cyc[1]), 128'd2);
        chk("b2b_rate2", 128'(beat_cyc[3] - beat_cyc[2]), 128'd1);

        // reset mid-packet
        beats    = {};
        beat_cyc = {};
        cmd_q.push_back(mk(6'h04, 32'h44, 32'hC, 8'd3));
        for (int i = 1; i <= 4; i++) din_q.push_back(32'(i));
        wait_beats("mid_cnt", 2);
        chk("mid_pre_valid", 128'(AXIS_M_TVALID), 128'd1);
        chk("mid_pre_data", 128'(AXIS_M_TDATA), 128'd3);
        RST_N     = 1'b0;
        cmd_q     = {};
        din_q     = {};
        CMD_VALID = 1'b0;
        DIN_VALID = 1'b0;
        #1;
        chk("mid_tvalid", 128'(AXIS_M_TVALID), 128'd0);
        chk("mid_busy", 128'(BUSY), 128'd0);
        chk("mid_din_ready", 128'(DIN_READY), 128'd0);
        repeat (2) step();
        RST_N = 1'b1;
        repeat (2) step();
        chk("mid_beats", 128'(beats.size()), 128'd2);
        chk("mid_no_last", 128'({beats[0].last, beats[1].last}), 128'd0);
        beats    = {};
        beat_cyc = {};
        cmd_q.push_back(mk(6'h09, 32'h99, 32'hD, 8'd0));
        din_q.push_back(32'h0000BEEF);
        wait_beats("post_cnt", 1);
        chk("post_beat", 128'(beats[0]),
            128'({32'h0000BEEF, 1'b1, 6'h09, 32'hD, 32'h99}));

        // stats over packets of 1, 2 and 4 words
        do_reset();
        chk("stats_clr", {PKT_CNT, WORD_CNT}, 128'd0);
        cmd_q.push_back(mk(6'h01, 32'h0, 32'h1, 8'd0));
        cmd_q.push_back(mk(6'h02, 32'h0, 32'h2, 8'd1));
        cmd_q.push_back(mk(6'h03, 32'h0, 32'h3, 8'd3));
        for (int i = 0; i < 7; i++) din_q.push_back(32'(100 + i));
        wait_beats("stats_beats", 7);
        repeat (3) step();
`ifdef AXIS_HOST_TX_STATS_EN
        chk("pkt_cnt", 128'(PKT_CNT), 128'd3);
        chk("word_cnt", 128'(WORD_CNT), 128'd7);
`else
        chk("pkt_cnt", 128'(PKT_CNT), 128'd0);
        chk("word_cnt", 128'(WORD_CNT), 128'd0);
`endif
        chk("stats_last", 128'({beats[0].last, beats[2].last, beats[6].last}),
            128'd7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
